alu_accum: RTL
==============

Name: alu_accum

Overview:
- ALU plus accumulator stage of the 8-bit RISC_CPU datapath, directly upstream of the data-bus tri-state driver.
- Computes a registered result from the current opcode, the data-bus operand and the accumulator.
- The result `alu_out` feeds the bus driver input; the driver places it on the bus for STO.
- The accumulator reloads from `alu_out` under control-FSM strobes; the zero flag is provided for SKZ.

Parameters:
- WIDTH, 8, datapath width of data, alu_out and accum.
- OPW, 3, opcode width; opcode encodings are fixed for OPW=3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_ena  input  1  strobe: register a new ALU result this edge.
- acc_ena  input  1  strobe: load accumulator from alu_out this edge.
- opcode  input  OPW  instruction opcode from the instruction register.
- data  input  WIDTH  operand read from the data bus (RAM/ROM).
- alu_out  output  WIDTH  registered ALU result, to the bus driver input.
- accum  output  WIDTH  accumulator contents.
- zero  output  1  combinational, 1 when accum == 0.
- carry  output  1  registered carry-out of the last ADD.

Behaviour:
- Reset (reset=1 at posedge) overrides all strobes: alu_out=0, accum=0, carry=0; zero therefore reads 1.
- ALU result, on posedge with alu_ena=1 and reset=0; alu_out is updated per opcode:
  - 000 HLT: accum
  - 001 SKZ: accum
  - 010 ADD: (data+accum) mod 2^WIDTH; carry takes bit WIDTH of the (WIDTH+1)-bit sum
  - 011 AND: data & accum
  - 100 XOR: data ^ accum
  - 101 LDA: data
  - 110 STO: accum
  - 111 JMP: accum
- Carry updates only on ADD with alu_ena=1; it holds through every other opcode.
- alu_ena=0: alu_out and carry hold.
- Latency: alu_out is valid 1 clk after the alu_ena edge; inputs are sampled only at that edge.
- Accumulator, on posedge with acc_ena=1 and reset=0: accum <= alu_out, taking the value registered before this edge.
- acc_ena=0: accum holds.
- Simultaneous alu_ena=1 and acc_ena=1 on the same edge:
  - accum loads the old alu_out.
  - alu_out computes from the old accum.
  - There is no combinational bypass.
- Zero is purely combinational from accum and updates in the same cycle accum changes.
- Arithmetic is unsigned; ADD overflow wraps (e.g. 8'hFF+8'h01 = 8'h00, carry=1).
- Reset asserted mid-sequence clears state on that edge; any strobe on the same edge is ignored.
- No tri-state outputs in this block: alu_out is always driven, and bus isolation belongs to the downstream driver.

Test Plan:
- Reset: assert reset 2 clks with alu_ena=acc_ena=1, data=8'h5A -> alu_out=0, accum=0, carry=0, zero=1.
- LDA then load: opcode=101, data=8'h3C, alu_ena pulse -> alu_out=8'h3C one clk later; then acc_ena pulse -> accum=8'h3C, zero=0.
- ADD wrap: accum=8'hFF, opcode=010, data=8'h01, alu_ena -> alu_out=8'h00, carry=1; acc_ena -> accum=0, zero=1. Follow with opcode=011, alu_ena -> carry remains 1.
- AND/XOR/pass-through: accum=8'hF0, data=8'h3C:
  - AND -> 8'h30
  - XOR -> 8'hCC
  - STO / JMP / HLT / SKZ -> 8'hF0 each, carry unchanged.
- Simultaneous strobes: alu_out=8'h11, accum=8'h22, opcode=101, data=8'h77, alu_ena=acc_ena=1 on one edge -> accum=8'h11, alu_out=8'h77.
- Hold and mid-op reset: strobes low for 5 clks -> all outputs stable. Then reset with acc_ena=1 -> accum=0 and acc_ena ignored.

Source files
------------

// File: rtl/alu_accum.sv
// alu_accum: registered ALU result plus accumulator for the 8-bit RISC_CPU
// datapath. alu_out feeds the downstream bus driver; zero serves SKZ.
module alu_accum #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_ena,
  input  logic             acc_ena,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] accum,
  output logic             zero,
  output logic             carry
);

  // Opcode encodings are fixed for a 3-bit opcode field.
  localparam logic [OPW-1:0] OP_HLT = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(3'b001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_AND = OPW'(3'b011);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3'b100);
  localparam logic [OPW-1:0] OP_LDA = OPW'(3'b101);
  localparam logic [OPW-1:0] OP_STO = OPW'(3'b110);
  localparam logic [OPW-1:0] OP_JMP = OPW'(3'b111);

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] accum_q,   accum_d;
  logic             carry_q,   carry_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] xor_res;

  // Widened sum so the carry-out is simply the top bit.
  assign sum = {1'b0, data} + {1'b0, accum_q};

  // Per-bit logic operations between the bus operand and the accumulator.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_res[gi] = data[gi] & accum_q[gi];
      assign xor_res[gi] = data[gi] ^ accum_q[gi];
    end
  endgenerate

  // Next-state: ALU result and carry on alu_ena, accumulator from the old
  // alu_out on acc_ena. Both read pre-edge state, so there is no bypass.
  always_comb begin
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    accum_d   = accum_q;
    if (alu_ena) begin
      unique case (opcode)
        OP_ADD: begin
          alu_out_d = sum[WIDTH-1:0];
          carry_d   = sum[WIDTH];
        end
        OP_AND: alu_out_d = and_res;
        OP_XOR: alu_out_d = xor_res;
        OP_LDA: alu_out_d = data;
        OP_HLT, OP_SKZ, OP_STO, OP_JMP: alu_out_d = accum_q;
        default: alu_out_d = accum_q;
      endcase
    end
    if (acc_ena) begin
      accum_d = alu_out_q;
    end
  end

  // State registers; reset wins over any strobe on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      accum_q   <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      accum_q   <= accum_d;
      carry_q   <= carry_d;
    end
  end

  assign alu_out = alu_out_q;
  assign accum   = accum_q;
  assign carry   = carry_q;
  assign zero    = (accum_q == '0);

endmodule
